alu_ctrl_idex: RTL
==================

# alu_ctrl_idex

Decode-side counterpart of the ALU bit-slice array: turns each ID-stage instruction into the 3-bit ALU operation code (AND 000, OR 001, ADD 010, SUB 110, SLT 111) plus EX/MEM/WB control bits, and registers them into the ID/EX pipeline register of the 5-stage CPU. Also performs load-use hazard detection, stalling IF/ID for one cycle and injecting a bubble, and honours branch flush and global hold.

## Interface
- No parameters; widths fixed by the MIPS-32 subset.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_instr  in  32  instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0])
- flush  in  1  branch resolved taken; kill instruction entering ID/EX
- hold  in  1  global freeze (memory wait); ID/EX keeps its contents
- stall  out  1  combinational load-use stall to PC and IF/ID (both hold)
- illegal  out  1  registered one-cycle pulse: unrecognised opcode/funct accepted
- ex_valid  out  1  ID/EX contains a real instruction
- ex_alu_sig  out  3  ALU Signal for EX
- ex_alu_src, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write  out  1 each
- ex_rs, ex_rt, ex_dst  out  5 each  source regs and write-back destination

## Operation
- Decode: R-type (opcode 0) funct 0x20 add->010, 0x22 sub->110, 0x24 and->000, 0x25 or->001, 0x2A slt->111; reg_dst=1, reg_write=1, dst=rd.
- lw (0x23): 010, alu_src, mem_read, reg_write, dst=rt. sw (0x2B): 010, alu_src, mem_write. beq (0x04): 110, branch. addi (0x08): 010, alu_src, reg_write, dst=rt.
- Unknown opcode/funct: loaded as bubble, illegal pulses one cycle.
- Writes to $0: reg_write forced 0, dst=0.
- Hazard: stall = id_valid & ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==rs | (uses_rt & ex_rt==rt)); uses_rt true for R-type, sw, beq.
- Register update priority per edge: hold (keep all) > flush (bubble) > stall (bubble) > load decoded instruction (ex_valid=id_valid).
- Bubble: ex_valid=0, all control bits 0, ex_alu_sig=000, regs 0.

## Timing
- Reset (async, immediate): ex_valid 0, ex_alu_sig 000, all control bits 0, ex_rs/ex_rt/ex_dst 0, illegal 0.
- Latency: decoded fields visible on ex_* one cycle after the ID edge.
- stall combinational from current ex_* and id_instr; lasts exactly one cycle (next cycle ID/EX holds a bubble so condition clears).
- Back-to-back lw then consumer: one bubble; lw then independent instr: no stall.
- flush with stall same cycle: bubble loaded, stall still asserted (IF/ID content is killed upstream anyway).
- hold with flush: freeze wins; upstream must keep flush asserted until hold drops. illegal not pulsed while hold.
- Reset deasserted mid-stream: first edge after release loads normally.

## Structure
- Shared package alu_pkg: ALU Signal constants (AND/OR/ADD/SUB/SLT), opcode and funct constants, control-bit struct for ID/EX.
- Sub-module alu_op_decode: purely combinational instr -> control bundle + legal flag; alu_ctrl_idex owns hazard logic and the register.

## Test plan
- Reset mid-run with ex_valid=1: all outputs 0 immediately, before next edge.
- add $3,$1,$2 (0x00221820) -> next cycle ex_alu_sig=010, reg_dst=1, reg_write=1, ex_dst=3; slt funct 0x2A -> 111; beq -> 110, branch=1.
- lw $5,0($1) then add $6,$5,$2 -> stall=1 one cycle, one bubble, add enters ID/EX on following edge; with $0 as lw target -> no stall.
- flush=1 alongside valid sw -> ex_valid=0, mem_write=0; hold=1 for 3 cycles -> ex_* unchanged throughout.
- opcode 0x3F -> ex_valid=0, illegal high exactly one cycle.
- addi $0,$1,5 -> ex_reg_write=0, ex_dst=0, ex_alu_sig=010.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU operation codes, MIPS-32 subset opcode/funct values and the ID/EX control bundle.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [2:0] alu_sig;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } idex_ctrl_t;

    localparam idex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode into the ID/EX control bundle plus legal flag.
// Zero latency; no flow control.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output idex_ctrl_t  o_ctrl,
    output logic        o_legal,
    output logic        o_uses_rt
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_rs     = i_instr[25:21];
    assign w_rt     = i_instr[20:16];
    assign w_rd     = i_instr[15:11];
    assign w_funct  = i_instr[5:0];
    assign w_unused = ^i_instr[10:6];

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_legal   = 1'b1;
        o_uses_rt = 1'b0;
        o_ctrl.rs = w_rs;
        o_ctrl.rt = w_rt;
        case (w_op)
            OP_RTYPE: begin
                o_uses_rt        = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.dst       = w_rd;
                case (w_funct)
                    FN_ADD:  o_ctrl.alu_sig = ALU_ADD;
                    FN_SUB:  o_ctrl.alu_sig = ALU_SUB;
                    FN_AND:  o_ctrl.alu_sig = ALU_AND;
                    FN_OR:   o_ctrl.alu_sig = ALU_OR;
                    FN_SLT:  o_ctrl.alu_sig = ALU_SLT;
                    default: o_legal        = 1'b0;
                endcase
            end
            OP_LW: begin
                o_ctrl.alu_sig   = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.dst       = w_rt;
            end
            OP_SW: begin
                o_uses_rt        = 1'b1;
                o_ctrl.alu_sig   = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                o_uses_rt        = 1'b1;
                o_ctrl.alu_sig   = ALU_SUB;
                o_ctrl.branch    = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.alu_sig   = ALU_ADD;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.dst       = w_rt;
            end
            default: o_legal = 1'b0;
        endcase
        // $0 is hard-wired: a write to it must never reach write-back
        if (o_ctrl.dst == 5'd0) begin
            o_ctrl.reg_write = 1'b0;
        end
        if (!o_legal) begin
            o_ctrl = CTRL_BUBBLE;
        end
    end

endmodule

// File: rtl/alu_ctrl_idex.sv
// ID/EX pipeline register with ALU-op decode, load-use stall, flush and hold.
// One-cycle latency ID->EX; hold freezes ID/EX, stall is combinational to PC and IF/ID.
module alu_ctrl_idex
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        flush,
    input  logic        hold,
    output logic        stall,
    output logic        illegal,
    output logic        ex_valid,
    output logic [2:0]  ex_alu_sig,
    output logic        ex_alu_src,
    output logic        ex_reg_dst,
    output logic        ex_branch,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst
);

    idex_ctrl_t w_dec;
    logic       w_legal;
    logic       w_uses_rt;
    logic [4:0] w_id_rs;
    logic [4:0] w_id_rt;
    logic       w_accept;

    idex_ctrl_t r_ex;
    logic       r_ex_valid;
    logic       r_illegal;

    alu_op_decode u_dec (
        .i_instr   (id_instr),
        .o_ctrl    (w_dec),
        .o_legal   (w_legal),
        .o_uses_rt (w_uses_rt)
    );

    assign w_id_rs = id_instr[25:21];
    assign w_id_rt = id_instr[20:16];

    assign stall = id_valid & r_ex_valid & r_ex.mem_read & (r_ex.rt != 5'd0)
                 & ((r_ex.rt == w_id_rs) | (w_uses_rt & (r_ex.rt == w_id_rt)));

    // A stalled instruction is re-presented next cycle, so it is only accepted once
    assign w_accept = id_valid & ~flush & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex       <= CTRL_BUBBLE;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (hold) begin
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= w_accept & ~w_legal;
            if (w_accept & w_legal) begin
                r_ex       <= w_dec;
                r_ex_valid <= 1'b1;
            end else begin
                r_ex       <= CTRL_BUBBLE;
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign illegal      = r_illegal;
    assign ex_valid     = r_ex_valid;
    assign ex_alu_sig   = r_ex.alu_sig;
    assign ex_alu_src   = r_ex.alu_src;
    assign ex_reg_dst   = r_ex.reg_dst;
    assign ex_branch    = r_ex.branch;
    assign ex_mem_read  = r_ex.mem_read;
    assign ex_mem_write = r_ex.mem_write;
    assign ex_reg_write = r_ex.reg_write;
    assign ex_rs        = r_ex.rs;
    assign ex_rt        = r_ex.rt;
    assign ex_dst       = r_ex.dst;

endmodule
